video_pattern_gen: RTL

- Self-timed video source that drives the same parallel video bus the HDMI receiver produces: dv/hs/vs plus 8-bit R/G/B.
- Feeds hdmi_tx, or fir2d through a mux, when no HDMI input is present.
- Used for bring-up and as a known stimulus for filter checks.
- Generates progressive timing from parameters, with selectable test patterns.

---
 rtl/video_pkg.sv | 59 +++++
 rtl/video_timing_gen.sv | 66 ++++++
 rtl/video_pattern_gen.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared video definitions: default 720p timing, pattern encodings, colour
// constants and the colour-bar lookup.
package video_pkg;

    // 1280x720 progressive timing defaults
    localparam int unsigned H_ACTIVE_720P = 1280;
    localparam int unsigned H_FP_720P     = 110;
    localparam int unsigned H_SYNC_720P   = 40;
    localparam int unsigned H_BP_720P     = 220;
    localparam int unsigned V_ACTIVE_720P = 720;
    localparam int unsigned V_FP_720P     = 5;
    localparam int unsigned V_SYNC_720P   = 5;
    localparam int unsigned V_BP_720P     = 20;

    localparam int unsigned PAT_W = 3;

    localparam logic [PAT_W-1:0] PAT_BARS  = 3'd0;
    localparam logic [PAT_W-1:0] PAT_RAMP  = 3'd1;
    localparam logic [PAT_W-1:0] PAT_CHECK = 3'd2;
    localparam logic [PAT_W-1:0] PAT_SOLID = 3'd3;
    localparam logic [PAT_W-1:0] PAT_MBAR  = 3'd4;

    // Moving bar geometry
    localparam int unsigned MBAR_WIDTH = 16;
    localparam int unsigned MBAR_STEP  = 4;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t COL_WHITE   = rgb_t'(24'hFFFFFF);
    localparam rgb_t COL_YELLOW  = rgb_t'(24'hFFFF00);
    localparam rgb_t COL_CYAN    = rgb_t'(24'h00FFFF);
    localparam rgb_t COL_GREEN   = rgb_t'(24'h00FF00);
    localparam rgb_t COL_MAGENTA = rgb_t'(24'hFF00FF);
    localparam rgb_t COL_RED     = rgb_t'(24'hFF0000);
    localparam rgb_t COL_BLUE    = rgb_t'(24'h0000FF);
    localparam rgb_t COL_BLACK   = rgb_t'(24'h000000);
    localparam rgb_t COL_GREY    = rgb_t'(24'h202020);

    // Colour of bar idx, left to right
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = COL_WHITE;
            3'd1:    c = COL_YELLOW;
            3'd2:    c = COL_CYAN;
            3'd3:    c = COL_GREEN;
            3'd4:    c = COL_MAGENTA;
            3'd5:    c = COL_RED;
            3'd6:    c = COL_BLUE;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Progressive raster timing: h/v counters plus active/sync decode and
// frame/line strobes, all combinational from the current counter state.
// Ports: clk, rst (async, active-high), enable (low clears counters);
//        h_cnt/v_cnt counters; dv_c, hs_c, vs_c (active-high "in sync"),
//        sof_c at (0,0), eof_c at the last cycle of a frame, line_end_c.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_720P,
    parameter int unsigned H_FP     = H_FP_720P,
    parameter int unsigned H_SYNC   = H_SYNC_720P,
    parameter int unsigned H_BP     = H_BP_720P,
    parameter int unsigned V_ACTIVE = V_ACTIVE_720P,
    parameter int unsigned V_FP     = V_FP_720P,
    parameter int unsigned V_SYNC   = V_SYNC_720P,
    parameter int unsigned V_BP     = V_BP_720P,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          dv_c,
    output logic          hs_c,
    output logic          vs_c,
    output logic          sof_c,
    output logic          eof_c,
    output logic          line_end_c
);

    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;

    logic last_line_c;

    assign line_end_c  = (32'(h_cnt) == H_TOTAL - 1);
    assign last_line_c = (32'(v_cnt) == V_TOTAL - 1);
    assign eof_c       = line_end_c && last_line_c;
    assign sof_c       = (h_cnt == '0) && (v_cnt == '0);

    assign dv_c = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    assign hs_c = (32'(h_cnt) >= HS_START) && (32'(h_cnt) < HS_START + H_SYNC);
    // v_cnt only changes at line wrap, so vs edges land on h_cnt=0
    assign vs_c = (32'(v_cnt) >= VS_START) && (32'(v_cnt) < VS_START + V_SYNC);

    // Raster counters; enable low restarts at pixel (0,0)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end_c) begin
            h_cnt <= '0;
            v_cnt <= last_line_c ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

endmodule

// File: rtl/video_pattern_gen.sv
// Self-timed test-pattern video source on the parallel dv/hs/vs/RGB bus.
// Ports: clk, rst (async, active-high), enable (low = idle, cleared),
//        pattern_sel/solid_rgb (captured at the start of each frame),
//        dv_o/hs_o/vs_o/r_o/g_o/b_o/frame_start_o registered one cycle
//        after the raster position they describe.
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = H_ACTIVE_720P,
    parameter int unsigned H_FP       = H_FP_720P,
    parameter int unsigned H_SYNC     = H_SYNC_720P,
    parameter int unsigned H_BP       = H_BP_720P,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_720P,
    parameter int unsigned V_FP       = V_FP_720P,
    parameter int unsigned V_SYNC     = V_SYNC_720P,
    parameter int unsigned V_BP       = V_BP_720P,
    parameter bit          HS_POL     = 1'b1,
    parameter bit          VS_POL     = 1'b1,
    parameter int unsigned CHECK_LOG2 = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [PAT_W-1:0] pattern_sel,
    input  logic [23:0]      solid_rgb,
    output logic             dv_o,
    output logic             hs_o,
    output logic             vs_o,
    output logic [7:0]       r_o,
    output logic [7:0]       g_o,
    output logic [7:0]       b_o,
    output logic             frame_start_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned BAR_W   = H_ACTIVE / 8;
    localparam int unsigned BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic [HW-1:0]    h_cnt;
    logic [VW-1:0]    v_cnt;
    logic             dv_c, hs_c, vs_c, sof_c, eof_c, line_end_c;

    logic [PAT_W-1:0] pat_q;
    rgb_t             solid_q;
    logic [BW-1:0]    bar_pix;
    logic [2:0]       bar_idx;
    logic [HW-1:0]    bar_x;
    logic [7:0]       frame_cnt;

    logic [PAT_W-1:0] pat_c;
    rgb_t             solid_c;
    logic             check_c;
    logic             in_bar_c;
    rgb_t             pix_c;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .dv_c       (dv_c),
        .hs_c       (hs_c),
        .vs_c       (vs_c),
        .sof_c      (sof_c),
        .eof_c      (eof_c),
        .line_end_c (line_end_c)
    );

    // Pixel (0,0) already uses the selection being captured, so the whole
    // frame is drawn with one pattern.
    assign pat_c   = sof_c ? pattern_sel : pat_q;
    assign solid_c = sof_c ? rgb_t'(solid_rgb) : solid_q;

    assign check_c  = (|(h_cnt & HW'(1 << CHECK_LOG2))) ^ (|(v_cnt & VW'(1 << CHECK_LOG2)));
    assign in_bar_c = (32'(h_cnt) >= 32'(bar_x)) && (32'(h_cnt) < 32'(bar_x) + MBAR_WIDTH);

    // Frame-boundary capture of the pattern selection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q   <= PAT_BARS;
            solid_q <= COL_BLACK;
        end else if (!enable) begin
            pat_q   <= PAT_BARS;
            solid_q <= COL_BLACK;
        end else if (sof_c) begin
            pat_q   <= pattern_sel;
            solid_q <= rgb_t'(solid_rgb);
        end
    end

    // Colour-bar index tracks h_cnt incrementally instead of dividing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bar_pix <= '0;
            bar_idx <= '0;
        end else if (!enable || line_end_c) begin
            bar_pix <= '0;
            bar_idx <= '0;
        end else if (32'(h_cnt) < H_ACTIVE) begin
            if (32'(bar_pix) == BAR_W - 1) begin
                bar_pix <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_pix <= bar_pix + BW'(1);
            end
        end
    end

    // Moving-bar position and frame counter advance on the last frame cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bar_x     <= '0;
            frame_cnt <= '0;
        end else if (!enable) begin
            bar_x     <= '0;
            frame_cnt <= '0;
        end else if (eof_c) begin
            bar_x     <= (32'(bar_x) + MBAR_STEP >= H_ACTIVE) ? '0 : bar_x + HW'(MBAR_STEP);
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // Pattern colour for the current raster position
    always_comb begin
        pix_c = COL_BLACK;
        case (pat_c)
            PAT_BARS:  pix_c = bar_colour(bar_idx);
            PAT_RAMP:  pix_c = '{r: 8'(h_cnt), g: 8'(h_cnt), b: 8'(h_cnt)};
            PAT_CHECK: pix_c = check_c ? COL_WHITE : COL_BLACK;
            PAT_SOLID: pix_c = solid_c;
            PAT_MBAR:  pix_c = in_bar_c ? COL_WHITE : COL_GREY;
            default:   pix_c = COL_BLACK;
        endcase
    end

    // Output registers: one cycle after the counter state, mutually aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_o          <= 1'b0;
            hs_o          <= ~HS_POL;
            vs_o          <= ~VS_POL;
            {r_o, g_o, b_o} <= '0;
            frame_start_o <= 1'b0;
        end else if (!enable) begin
            dv_o          <= 1'b0;
            hs_o          <= ~HS_POL;
            vs_o          <= ~VS_POL;
            {r_o, g_o, b_o} <= '0;
            frame_start_o <= 1'b0;
        end else begin
            dv_o          <= dv_c;
            hs_o          <= hs_c ? HS_POL : ~HS_POL;
            vs_o          <= vs_c ? VS_POL : ~VS_POL;
            {r_o, g_o, b_o} <= dv_c ? pix_c : COL_BLACK;
            frame_start_o <= sof_c;
        end
    end

endmodule
